// File: rtl/mole_recorder.sv
// mole_recorder: records a DIY mole schedule from pad stomps and plays it back.
//
// While recording, each accepted stomp stores {music_address, stomp_location}.
// Consecutive entries must be at least MIN_GAP addresses apart. During playback
// the entries are read in order. When the song reaches an entry's address, the
// block emits a one-cycle request_mole with that entry's location.
//
// Optional feature macro: MOLE_REC_LOOP_EN. When it is defined, playback does
// not finish. After the last entry the block waits in WRAP until the song
// restarts, then replays from entry 0.
//
// Ports:
//   clk, reset_n       clock; asynchronous active-low reset
//   record_start       pulse: clear buffer and start recording
//   record_stop        pulse: stop recording
//   play_start         pulse: start playback from entry 0
//   stomp              one-cycle pad press; stomp_location valid with it
//   music_address      current audio sample address (monotonic within a song)
//   request_mole       one-cycle pulse per played entry
//   mole_location      location of the last played entry (held)
//   count, full        number of valid entries; count == DEPTH
//   recording, playing status flags
//   done               one-cycle pulse when playback finishes
//   dbg_state          current FSM state, for observation
//
// Handshake: the block has no valid/ready pairs. Every input is sampled on the
// rising clock edge. Every output event is a single-cycle pulse with no
// backpressure.
module mole_recorder #(
    parameter int          DEPTH   = 16,
    parameter logic [22:0] MIN_GAP = 23'h2000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     record_start,
    input  logic                     record_stop,
    input  logic                     play_start,
    input  logic                     stomp,
    input  logic [2:0]               stomp_location,
    input  logic [22:0]              music_address,
    output logic                     request_mole,
    output logic [2:0]               mole_location,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     recording,
    output logic                     playing,
    output logic                     done,
    output logic [2:0]               dbg_state
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECORD = 3'd1,
        PLAY   = 3'd2,
        MOLE   = 3'd3
`ifdef MOLE_REC_LOOP_EN
        ,WRAP  = 3'd4
`endif
    } state_t;

    state_t       state_q, state_d;
    logic [AW:0]  count_q, count_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         last_valid_q, last_valid_d;
    logic [22:0]  last_addr_q, last_addr_d;
    logic [2:0]   mole_loc_q, mole_loc_d;
    logic         done_q, done_d;
    logic         wr_en;

    logic [25:0]  mem_q [DEPTH];
    logic [25:0]  rd_entry;
    logic         stomp_ok;

    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    // The gap sum is formed at 24 bits so that a late last_addr cannot wrap.
    // A lower address then never passes the check.
    assign stomp_ok = stomp && (count_q != DEPTH_C) &&
                      (!last_valid_q ||
                       ({1'b0, music_address} >= ({1'b0, last_addr_q} + {1'b0, MIN_GAP})));

`ifdef MOLE_REC_LOOP_EN
    logic [AW-1:0] last_idx;
    logic [25:0]   last_entry;
    assign last_idx   = AW'(count_q - 1'b1);
    assign last_entry = mem_q[last_idx];
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        last_valid_d = last_valid_q;
        last_addr_d  = last_addr_q;
        mole_loc_d   = mole_loc_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (record_start) begin
                    state_d      = RECORD;
                    count_d      = '0;
                    last_valid_d = 1'b0;
                end else if (play_start) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                end
            end
            RECORD: begin
                // A stomp that arrives with record_stop is still captured.
                if (stomp_ok) begin
                    wr_en        = 1'b1;
                    count_d      = count_q + 1'b1;
                    last_valid_d = 1'b1;
                    last_addr_d  = music_address;
                end
                if (record_stop || (count_d == DEPTH_C)) begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (record_start) begin
                    state_d      = RECORD;
                    count_d      = '0;
                    last_valid_d = 1'b0;
                end else if (rd_ptr_q == count_q) begin
`ifdef MOLE_REC_LOOP_EN
                    if (count_q != '0) begin
                        state_d = WRAP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    done_d  = 1'b1;
                    state_d = IDLE;
`endif
                end else if (music_address >= rd_entry[25:3]) begin
                    // The >= comparison fires even if the song skipped past
                    // the exact recorded address.
                    mole_loc_d = rd_entry[2:0];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    state_d    = MOLE;
                end
            end
            MOLE: begin
                if (record_start) begin
                    state_d      = RECORD;
                    count_d      = '0;
                    last_valid_d = 1'b0;
                end else begin
                    state_d = PLAY;
                end
            end
`ifdef MOLE_REC_LOOP_EN
            WRAP: begin
                if (record_start) begin
                    state_d      = RECORD;
                    count_d      = '0;
                    last_valid_d = 1'b0;
                end else if (music_address < last_entry[25:3]) begin
                    // The address fell below the last entry, so the song
                    // has restarted.
                    rd_ptr_d = '0;
                    state_d  = PLAY;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            mole_loc_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            mole_loc_q   <= mole_loc_d;
            done_q       <= done_d;
        end
    end

    // Buffer contents are don't-care after reset, so this storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= {music_address, stomp_location};
        end
    end

    assign request_mole  = (state_q == MOLE);
    assign mole_location = mole_loc_q;
    assign count         = count_q;
    assign full          = (count_q == DEPTH_C);
    assign recording     = (state_q == RECORD);
`ifdef MOLE_REC_LOOP_EN
    assign playing       = (state_q == PLAY) || (state_q == MOLE) || (state_q == WRAP);
`else
    assign playing       = (state_q == PLAY) || (state_q == MOLE);
`endif
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule
